// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and types for the NTT datapath blocks.
//   N      coefficients per polynomial
//   DW     coefficient width
//   Q      modulus
//   MU     Barrett constant floor(2^(2*DW) / Q)
//   coef_t coefficient type, idx_t coefficient index type
//   state_t pointwise-multiplier control states
package ntt_pkg;

    localparam int unsigned N  = 256;
    localparam int unsigned DW = 23;
    localparam int unsigned IW = $clog2(N);

    localparam logic [DW-1:0] Q = 23'd8380417;

    localparam logic [63:0] MU_FULL = (64'd1 << (2 * DW)) / 64'(Q);
    localparam logic [DW:0]   MU      = MU_FULL[DW:0];

    typedef logic [DW-1:0] coef_t;
    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY,
        STREAM
    } state_t;

endpackage

// File: rtl/mod_mul_q.sv
// mod_mul_q: 3-stage pipelined (a * b) mod Q with valid/last sideband.
//   clk, rst_n      clock, async active-low reset
//   i_valid/i_last  operand valid and last-coefficient tag
//   i_a, i_b        operands, any value in [0, 2^DW-1]
//   o_valid/o_last  result valid and tag, 3 cycles after the operands
//   o_data          exact (a * b) mod Q; holds while o_valid is low
module mod_mul_q
    import ntt_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic          i_last,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic          o_valid,
    output logic          o_last,
    output logic [DW-1:0] o_data
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned QW = DW + 1;
    localparam logic [PW:0] QX = {{(PW + 1 - DW){1'b0}}, Q};

    logic [PW-1:0] r_p2, r_p3;
    logic [QW-1:0] r_q3;
    logic          r_v2, r_l2, r_v3, r_l3, r_v4, r_l4;
    logic [DW-1:0] r_data;

    logic [QW-1:0] w_q;
    logic [PW:0]   w_r0, w_r1, w_r2;

    // Full-precision quotient estimate; undershoots floor(p/Q) by at most 2.
    assign w_q = QW'(({{QW{1'b0}}, r_p2} * {{PW{1'b0}}, MU}) >> PW);

    // q*Q <= p, so the remainder is non-negative and below 3Q.
    assign w_r0 = {1'b0, r_p3} - ({{DW{1'b0}}, r_q3} * {{QW{1'b0}}, Q});
    assign w_r1 = (w_r0 >= QX) ? (w_r0 - QX) : w_r0;
    assign w_r2 = (w_r1 >= QX) ? (w_r1 - QX) : w_r1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p2   <= '0;
            r_v2   <= 1'b0;
            r_l2   <= 1'b0;
            r_p3   <= '0;
            r_q3   <= '0;
            r_v3   <= 1'b0;
            r_l3   <= 1'b0;
            r_v4   <= 1'b0;
            r_l4   <= 1'b0;
            r_data <= '0;
        end else begin
            r_p2 <= {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
            r_v2 <= i_valid;
            r_l2 <= i_last;
            r_p3 <= r_p2;
            r_q3 <= w_q;
            r_v3 <= r_v2;
            r_l3 <= r_l2;
            r_v4 <= r_v3;
            r_l4 <= r_v3 & r_l3;
            if (r_v3) begin
                r_data <= DW'(w_r2);
            end
        end
    end

    assign o_valid = r_v4;
    assign o_last  = r_l4;
    assign o_data  = r_data;

endmodule

// File: rtl/ntt_pointwise_mul.sv
// ntt_pointwise_mul: multiplies the NTT output stream by a preloaded polynomial B mod Q.
//   clk, rst_n                       clock, async active-low reset
//   i_b_load_valid/o_b_load_ready    B load handshake, i_b_load_data in index order
//   i_in_valid, i_in_data            NTT coefficient stream, no backpressure
//   o_out_valid, o_out_data          product stream, 4 cycles after the input beat
//   o_out_last                       tags the product of coefficient N-1
//   o_b_ready                        B fully loaded
//   o_err_drop                       sticky: a beat arrived while B was not usable
module ntt_pointwise_mul
    import ntt_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_b_load_valid,
    output logic          o_b_load_ready,
    input  logic [DW-1:0] i_b_load_data,
    input  logic          i_in_valid,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_valid,
    output logic [DW-1:0] o_out_data,
    output logic          o_out_last,
    output logic          o_b_ready,
    output logic          o_err_drop
);

    localparam idx_t IDX_LAST = idx_t'(N - 1);

    state_t r_state, w_state_d;
    idx_t   r_load_cnt, r_in_cnt;
    logic   r_b_ready, r_err_drop;
    coef_t  r_b_mem [N];
    coef_t  r_a1, r_b1;
    logic   r_v1, r_l1;

    logic w_load_ready, w_load_fire, w_in_fire, w_drop;

    always_comb begin
        w_state_d    = r_state;
        // A beat in READY takes priority over a reload in the same cycle.
        w_load_ready = (r_state != STREAM) && !((r_state == READY) && i_in_valid);
        w_load_fire  = i_b_load_valid && w_load_ready;
        w_in_fire    = i_in_valid && ((r_state == READY) || (r_state == STREAM));
        w_drop       = i_in_valid && ((r_state == EMPTY) || (r_state == LOAD));
        unique case (r_state)
            EMPTY: begin
                if (w_load_fire) w_state_d = LOAD;
            end
            LOAD: begin
                if (w_load_fire && (r_load_cnt == IDX_LAST)) w_state_d = READY;
            end
            READY: begin
                if (w_in_fire) w_state_d = STREAM;
                else if (w_load_fire) w_state_d = LOAD;
            end
            STREAM: begin
                if (w_in_fire && (r_in_cnt == IDX_LAST)) w_state_d = READY;
            end
            default: w_state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_load_cnt <= '0;
            r_in_cnt   <= '0;
            r_b_ready  <= 1'b0;
            r_err_drop <= 1'b0;
            r_a1       <= '0;
            r_b1       <= '0;
            r_v1       <= 1'b0;
            r_l1       <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_b_ready <= (w_state_d == READY) || (w_state_d == STREAM);
            // Counters wrap naturally at N, leaving 0 for the next load/polynomial.
            if (w_load_fire) r_load_cnt <= r_load_cnt + 1'b1;
            if (w_in_fire)   r_in_cnt   <= r_in_cnt + 1'b1;
            if (w_drop)      r_err_drop <= 1'b1;
            r_v1 <= w_in_fire;
            if (w_in_fire) begin
                r_a1 <= i_in_data;
                r_b1 <= r_b_mem[r_in_cnt];
                r_l1 <= (r_in_cnt == IDX_LAST);
            end
        end
    end

    // B storage has no reset; contents are only trusted once a full load completes.
    always_ff @(posedge clk) begin
        if (w_load_fire) r_b_mem[r_load_cnt] <= i_b_load_data;
    end

    mod_mul_q u_mod_mul_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_v1),
        .i_last  (r_l1),
        .i_a     (r_a1),
        .i_b     (r_b1),
        .o_valid (o_out_valid),
        .o_last  (o_out_last),
        .o_data  (o_out_data)
    );

    assign o_b_load_ready = w_load_ready;
    assign o_b_ready      = r_b_ready;
    assign o_err_drop     = r_err_drop;

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// tb_ntt_pointwise_mul: directed and random stimulus against a behavioural model.
module tb_ntt_pointwise_mul;

    localparam int              N   = 256;
    localparam longint unsigned Q   = 64'd8380417;
    localparam logic [22:0]     MAX = 23'd8388607;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        b_load_valid, b_load_ready, in_valid;
    logic [22:0] b_load_data, in_data, out_data;
    logic        out_valid, out_last, b_ready, err_drop;

    always #5 clk = ~clk;

    ntt_pointwise_mul dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_b_load_valid (b_load_valid),
        .o_b_load_ready (b_load_ready),
        .i_b_load_data  (b_load_data),
        .i_in_valid     (in_valid),
        .i_in_data      (in_data),
        .o_out_valid    (out_valid),
        .o_out_data     (out_data),
        .o_out_last     (out_last),
        .o_b_ready      (b_ready),
        .o_err_drop     (err_drop)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int n_last   = 0;

    // Behavioural model: B contents, load/stream positions, expected outputs keyed by cycle.
    longint unsigned m_b [N];
    bit              m_bfull;
    int              m_load_cnt;
    int              m_in_cnt;
    bit              m_err;
    logic [22:0]     m_last_data;
    bit              exp_v [int];
    logic [22:0]     exp_d [int];
    bit              exp_l [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_clear();
        m_bfull     = 1'b0;
        m_load_cnt  = 0;
        m_in_cnt    = 0;
        m_err       = 1'b0;
        m_last_data = '0;
        exp_v.delete();
        exp_d.delete();
        exp_l.delete();
    endtask

    // One clock: apply inputs, update the model, advance to the next negedge and check.
    task automatic step(input bit bv, input logic [22:0] bd, input bit iv, input logic [22:0] id);
        bit lr;
        b_load_valid = bv;
        b_load_data  = bd;
        in_valid     = iv;
        in_data      = id;
        lr = (m_in_cnt == 0) && !(m_bfull && iv);
        #1;
        chk("b_load_ready", 32'(b_load_ready), 32'(lr));
        if (iv) begin
            if (m_bfull) begin
                exp_v[cyc + 4] = 1'b1;
                exp_d[cyc + 4] = 23'((longint'(id) * m_b[m_in_cnt]) % Q);
                exp_l[cyc + 4] = (m_in_cnt == N - 1);
                m_in_cnt = (m_in_cnt + 1) % N;
            end else begin
                m_err = 1'b1;
            end
        end
        if (bv && lr) begin
            if (m_bfull) m_bfull = 1'b0;
            m_b[m_load_cnt] = longint'(bd);
            m_load_cnt = (m_load_cnt + 1) % N;
            if (m_load_cnt == 0) m_bfull = 1'b1;
        end
        @(negedge clk);
        cyc++;
        if (out_valid) begin
            n_out++;
            if (out_last) n_last++;
        end
        if (exp_v.exists(cyc)) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_data", 32'(out_data), 32'(exp_d[cyc]));
            chk("out_last", 32'(out_last), 32'(exp_l[cyc]));
            m_last_data = exp_d[cyc];
            exp_v.delete(cyc);
            exp_d.delete(cyc);
            exp_l.delete(cyc);
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
            chk("out_data_hold", 32'(out_data), 32'(m_last_data));
        end
        chk("b_ready", 32'(b_ready), 32'(m_bfull));
        chk("err_drop", 32'(err_drop), 32'(m_err));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic load_const(input logic [22:0] v);
        repeat (N) step(1'b1, v, 1'b0, '0);
    endtask

    task automatic load_random();
        repeat (N) step(1'b1, 23'($urandom_range(0, 8388607)), 1'b0, '0);
    endtask

    // mode 0: constant val, 1: index ramp, 2: random; gaps inserts random idle cycles.
    task automatic stream_poly(input int mode, input logic [22:0] val, input bit gaps);
        int k;
        logic [22:0] d;
        k = 0;
        while (k < N) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                step(1'b0, '0, 1'b0, '0);
            end else begin
                d = (mode == 0) ? val : (mode == 1) ? 23'(k) : 23'($urandom_range(0, 8388607));
                step(1'b0, '0, 1'b1, d);
                k++;
            end
        end
    endtask

    task automatic do_reset();
        b_load_valid = 1'b0;
        in_valid     = 1'b0;
        rst_n        = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        b_load_valid = 1'b0;
        b_load_data  = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_b_load_ready", 32'(b_load_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_err_drop", 32'(err_drop), 32'd0);
        rst_n = 1'b1;

        // Identity B, index ramp; latency and out_last come from the model schedule.
        load_const(23'd1);
        stream_poly(1, '0, 1'b0);
        idle(6);
        chk("ramp_final", 32'(out_data), 32'd255);

        load_const(23'd3);
        stream_poly(0, 23'd2, 1'b1);
        idle(6);
        chk("three_times_two", 32'(out_data), 32'd6);
        load_const(23'(Q - 1));
        stream_poly(0, 23'(Q - 1), 1'b0);
        idle(6);
        chk("qm1_squared", 32'(out_data), 32'd1);

        load_const(MAX);
        stream_poly(0, MAX, 1'b0);
        idle(6);
        chk("max_squared", 32'(out_data), 32'd32764);

        // Eight back-to-back polynomials against one random B.
        load_random();
        n_out  = 0;
        n_last = 0;
        repeat (8) stream_poly(2, '0, 1'b0);
        idle(6);
        chk("b2b_outputs", 32'(n_out), 32'd2048);
        chk("b2b_last_pulses", 32'(n_last), 32'd8);
        chk("b2b_err_drop", 32'(err_drop), 32'd0);
        load_const(23'd5);
        stream_poly(0, 23'd7, 1'b0);
        idle(6);
        chk("reload_product", 32'(out_data), 32'd35);

        // Beat before B is loaded is dropped; collision in READY favours the beat.
        do_reset();
        step(1'b0, '0, 1'b1, 23'd5);
        idle(6);
        chk("drop_sticky", 32'(err_drop), 32'd1);
        do_reset();
        load_const(23'd2);
        step(1'b1, 23'd99, 1'b1, 23'd7);
        repeat (N - 1) step(1'b0, '0, 1'b1, 23'd7);
        idle(6);
        chk("collision_product", 32'(out_data), 32'd14);

        // Asynchronous reset in the middle of a polynomial.
        load_random();
        for (int k = 0; k < 100; k++) step(1'b0, '0, 1'b1, 23'($urandom_range(0, 8388607)));
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_b_ready", 32'(b_ready), 32'd0);
        model_clear();
        b_load_valid = 1'b0;
        in_valid     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        step(1'b0, '0, 1'b1, 23'd3);
        idle(5);

        // Random traffic: loads, reloads, collisions, gaps and dropped beats.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 7) == 0) || !m_bfull, 23'($urandom_range(0, 8388607)),
                 $urandom_range(0, 3) != 0, 23'($urandom_range(0, 8388607)));
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
